// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- handshaked sequential ALU with registered result and status flags.
//
// The block takes one operation at a time. A, B, Cin and S are captured on the
// acceptance edge (in_valid && in_ready). The block then works in BUSY for k
// cycles and holds the result in DONE until the consumer takes it with
// out_ready.
//
// Operation select S:
//   0_0xx  arithmetic. Each is a (WIDTH+1)-bit sum; Cout is the sum's top bit.
//          00: A+Cin, 01: A+B+Cin, 10: A+~B+Cin, 11: A+all_ones+Cin.
//   0_1xx  logic. The function is chosen by {S[0],Cin}:
//          00: AND, 01: OR, 10: XOR, 11: ~A.
//   1_x00  SHL by B[SHW-1:0], one bit per cycle.
//   1_x01  SHR by B[SHW-1:0], one bit per cycle.
//   1_x10  SAR by B[SHW-1:0], one bit per cycle.
//   1_x11  unsigned MUL by shift-add, one multiplier bit per cycle.
//
// Configuration macro:
//   ALU_SEQ_MUL_EN  when defined, builds the multiplier (2*WIDTH-bit product
//                   register, WIDTH steps). When undefined, S=1x11 completes
//                   in one cycle with Data=0, Cout=0, V=1 (illegal operation).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operation request
//   in_ready   block can accept an operation (high only in IDLE)
//   A, B       operands (B[SHW-1:0] is the shift amount for shifts)
//   Cin        carry-in, also selects the logic function
//   S          operation select
//   out_valid  Data and flags are valid (DONE)
//   out_ready  consumer accepts the result
//   Data       registered result
//   Cout, Z, N, V  carry, zero, negative and signed-overflow flags
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Data,
  output logic             Cout,
  output logic             Z,
  output logic             N,
  output logic             V
);

  // The step counter must hold WIDTH itself (the MUL step count).
  localparam int CW = SHW + 1;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [CW-1:0] K_MUL = CW'(WIDTH);
`else
  localparam logic [CW-1:0] K_MUL = CW'(1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured operation
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;
  logic [3:0]       s_q;

  // Step counter and shift working register
  logic [CW-1:0]    cnt_q, k_in;
  logic [WIDTH-1:0] work_q;

  // Registered result and flags
  logic [WIDTH-1:0] data_q;
  logic             cout_q, z_q, n_q, v_q;

  // Combinational next result, valid on the last BUSY step
  logic [WIDTH-1:0] res_d;
  logic             cout_d, v_d;

  logic [WIDTH-1:0] b_term;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] step_val;
  logic             step_out;

  logic accept;
  logic last_step;
  logic amt_zero;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     mul_sum;
`endif

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_q == CW'(1));
  assign amt_zero  = (b_q[SHW-1:0] == '0);

  // ---------------------------------------------------------------------------
  // Step count for the operation being accepted. Shifts by zero still take
  // one cycle so that every operation passes through BUSY.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    k_in = CW'(1);
    if (S[3] && (S[1:0] == 2'b11)) begin
      k_in = K_MUL;
    end else if (S[3] && (B[SHW-1:0] != '0)) begin
      k_in = {1'b0, B[SHW-1:0]};
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // Right-shifting shift-add: the low half starts as the multiplier; each step
  // conditionally adds A into the high half and shifts the whole register.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
            + {1'b0, ({WIDTH{prod_q[0]}} & a_q)};
    prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
  end
`endif

  // ---------------------------------------------------------------------------
  // Result datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    res_d    = '0;
    cout_d   = 1'b0;
    v_d      = 1'b0;
    step_val = work_q;
    step_out = 1'b0;

    // Second addend of the arithmetic group
    unique case (s_q[1:0])
      2'b00:   b_term = '0;
      2'b01:   b_term = b_q;
      2'b10:   b_term = ~b_q;
      default: b_term = '1;
    endcase
    sum = {1'b0, a_q} + {1'b0, b_term} + {{WIDTH{1'b0}}, cin_q};

    // One-bit shift step; step_out is the bit leaving the register
    unique case (s_q[1:0])
      2'b00: begin
        step_val = {work_q[WIDTH-2:0], 1'b0};
        step_out = work_q[WIDTH-1];
      end
      2'b01: begin
        step_val = {1'b0, work_q[WIDTH-1:1]};
        step_out = work_q[0];
      end
      default: begin
        step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_out = work_q[0];
      end
    endcase

    if (!s_q[3]) begin
      if (!s_q[2]) begin
        res_d  = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
        // Overflow: both addends share a sign that the sum does not.
        v_d    = (a_q[WIDTH-1] == b_term[WIDTH-1]) &&
                 (sum[WIDTH-1] != a_q[WIDTH-1]);
      end else begin
        unique case ({s_q[0], cin_q})
          2'b00:   res_d = a_q & b_q;
          2'b01:   res_d = a_q | b_q;
          2'b10:   res_d = a_q ^ b_q;
          default: res_d = ~a_q;
        endcase
      end
    end else if (s_q[1:0] == 2'b11) begin
`ifdef ALU_SEQ_MUL_EN
      res_d  = prod_d[WIDTH-1:0];
      cout_d = |prod_d[2*WIDTH-1:WIDTH];
`else
      v_d    = 1'b1;
`endif
    end else if (amt_zero) begin
      res_d = a_q;
    end else begin
      res_d  = step_val;
      cout_d = step_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      s_q    <= '0;
      cnt_q  <= '0;
      work_q <= '0;
      data_q <= '0;
      cout_q <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      prod_q <= '0;
`endif
    end else if (accept) begin
      a_q    <= A;
      b_q    <= B;
      cin_q  <= Cin;
      s_q    <= S;
      cnt_q  <= k_in;
      work_q <= A;
`ifdef ALU_SEQ_MUL_EN
      prod_q <= {{WIDTH{1'b0}}, B};
`endif
    end else if (state_q == BUSY) begin
      cnt_q  <= cnt_q - CW'(1);
      work_q <= step_val;
`ifdef ALU_SEQ_MUL_EN
      prod_q <= prod_d;
`endif
      if (last_step) begin
        data_q <= res_d;
        cout_q <= cout_d;
        z_q    <= (res_d == '0);
        n_q    <= res_d[WIDTH-1];
        v_q    <= v_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    Data      = data_q;
    Cout      = cout_q;
    Z         = z_q;
    N         = n_q;
    V         = v_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH=8).
// Expected values are hand-computed; MUL expectations follow ALU_SEQ_MUL_EN.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int WIDTH = 8;
  localparam int TMO   = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A, B;
  logic             Cin;
  logic [3:0]       S;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Data;
  logic             Cout, Z, N, V;

  int n_tests = 0;
  int n_fail  = 0;

  // f = {Cout, Z, N, V}
  typedef struct packed {
    logic [3:0] s;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] d;
    logic [3:0] f;
    logic [7:0] lat;
  } vec_t;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .S         (S),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Data      (Data),
    .Cout      (Cout),
    .Z         (Z),
    .N         (N),
    .V         (V)
  );

  always #5 clk = ~clk;

  // Issue one operation from IDLE and count edges until out_valid.
  // Operands are scrambled right after acceptance; they must not matter.
  task automatic do_op(input logic [3:0] s, input logic [7:0] a,
                       input logic [7:0] b, input logic cin, output int lat);
    S = s; A = a; B = b; Cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = ~a; B = ~b; Cin = ~cin; S = ~s;
    lat = 0;
    while (out_valid !== 1'b1 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if ({out_valid, in_ready, Data, Cout, Z, N, V} !== {1'b0, 1'b1, 8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_init: got ov=%b ir=%b d=%h f=%b%b%b%b, expected ov=0 ir=1 d=00 f=0000",
               out_valid, in_ready, Data, Cout, Z, N, V);
    end
    // Leave a non-zero result behind so the mid-op reset visibly clears it.
    do_op(4'b0001, 8'h7F, 8'h01, 1'b0, lat);
    take_result();
    // Start a long operation and reset it while BUSY.
`ifdef ALU_SEQ_MUL_EN
    S = 4'b1011; A = 8'hFF; B = 8'hFF;
`else
    S = 4'b1000; A = 8'h01; B = 8'h07;
`endif
    Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if ({out_valid, in_ready, Data, Cout, Z, N, V} !== {1'b0, 1'b1, 8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_busy: got ov=%b ir=%b d=%h f=%b%b%b%b, expected ov=0 ir=1 d=00 f=0000",
               out_valid, in_ready, Data, Cout, Z, N, V);
    end
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_abort: got ov=%b ir=%b, expected ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic run_table(input string name, input vec_t tbl[], input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      do_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].cin, lat);
      n_tests++;
      if ({Data, Cout, Z, N, V} !== {tbl[i].d, tbl[i].f} || lat != int'(tbl[i].lat)) begin
        n_fail++;
        $display("FAIL %s[%0d] S=%b A=%h B=%h Cin=%b: got d=%h f=%b%b%b%b lat=%0d, expected d=%h f=%b lat=%0d",
                 name, i, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].cin,
                 Data, Cout, Z, N, V, lat, tbl[i].d, tbl[i].f, tbl[i].lat);
      end
      take_result();
    end
  endtask

  task automatic test_arith();
    vec_t t[] = new[7];
    t[0] = '{4'b0001, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011, 8'd1};
    t[1] = '{4'b0010, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1100, 8'd1};
    t[2] = '{4'b0000, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1100, 8'd1};
    t[3] = '{4'b0011, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0010, 8'd1};
    t[4] = '{4'b0011, 8'h80, 8'h00, 1'b0, 8'h7F, 4'b1001, 8'd1};
    t[5] = '{4'b0010, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b1001, 8'd1};
    t[6] = '{4'b0011, 8'h5A, 8'h33, 1'b1, 8'h5A, 4'b1000, 8'd1};
    run_table("arith", t, 7);
  endtask

  task automatic test_logic();
    vec_t t[] = new[5];
    t[0] = '{4'b0100, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000, 8'd1};
    t[1] = '{4'b0100, 8'hF0, 8'h3C, 1'b1, 8'hFC, 4'b0010, 8'd1};
    t[2] = '{4'b0111, 8'hF0, 8'h3C, 1'b0, 8'hCC, 4'b0010, 8'd1};
    t[3] = '{4'b0111, 8'hF0, 8'h3C, 1'b1, 8'h0F, 4'b0000, 8'd1};
    t[4] = '{4'b0100, 8'h0F, 8'hF0, 1'b0, 8'h00, 4'b0100, 8'd1};
    run_table("logic", t, 5);
  endtask

  task automatic test_shift();
    vec_t t[] = new[7];
    t[0] = '{4'b1010, 8'h81, 8'hFB, 1'b0, 8'hF0, 4'b0010, 8'd3};
    t[1] = '{4'b1000, 8'h81, 8'h00, 1'b0, 8'h81, 4'b0010, 8'd1};
    t[2] = '{4'b1000, 8'h81, 8'h01, 1'b0, 8'h02, 4'b1000, 8'd1};
    t[3] = '{4'b1001, 8'h81, 8'h01, 1'b1, 8'h40, 4'b1000, 8'd1};
    t[4] = '{4'b1001, 8'h81, 8'h07, 1'b0, 8'h01, 4'b0000, 8'd7};
    t[5] = '{4'b1110, 8'h80, 8'h07, 1'b0, 8'hFF, 4'b0010, 8'd7};
    t[6] = '{4'b1100, 8'h40, 8'h02, 1'b0, 8'h00, 4'b1100, 8'd2};
    run_table("shift", t, 7);
  endtask

  task automatic test_mul();
    vec_t t[] = new[4];
`ifdef ALU_SEQ_MUL_EN
    t[0] = '{4'b1011, 8'h10, 8'h20, 1'b0, 8'h00, 4'b1100, 8'd8};
    t[1] = '{4'b1011, 8'h0F, 8'h0F, 1'b0, 8'hE1, 4'b0010, 8'd8};
    t[2] = '{4'b1111, 8'hFF, 8'hFF, 1'b0, 8'h01, 4'b1000, 8'd8};
    t[3] = '{4'b1011, 8'h0D, 8'h0B, 1'b1, 8'h8F, 4'b0010, 8'd8};
`else
    t[0] = '{4'b1011, 8'h10, 8'h20, 1'b0, 8'h00, 4'b0101, 8'd1};
    t[1] = '{4'b1011, 8'h0F, 8'h0F, 1'b0, 8'h00, 4'b0101, 8'd1};
    t[2] = '{4'b1111, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b0101, 8'd1};
    t[3] = '{4'b1011, 8'h0D, 8'h0B, 1'b1, 8'h00, 4'b0101, 8'd1};
`endif
    run_table("mul", t, 4);
  endtask

  task automatic test_backpressure();
    int lat;
    // SHR 0xF0 by 4: 0x0F, last bit out is bit 3 (0).
    S = 4'b1001; A = 8'hF0; B = 8'h04; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < TMO) begin
      A = 8'h0F ^ 8'(lat); B = 8'h01; S = 4'b0001; Cin = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if ({Data, Cout, Z, N, V} !== {8'h0F, 4'b0000} || lat != 4) begin
      n_fail++;
      $display("FAIL bp_result: got d=%h f=%b%b%b%b lat=%0d, expected d=0f f=0000 lat=4",
               Data, Cout, Z, N, V, lat);
    end
    // Hold DONE with new requests pending; they must be ignored.
    in_valid = 1'b1; A = 8'h11; B = 8'h22; S = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, in_ready, Data, Cout, Z, N, V} !== {1'b1, 1'b0, 8'h0F, 4'b0000}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b d=%h f=%b%b%b%b, expected ov=1 ir=0 d=0f f=0000",
                 i, out_valid, in_ready, Data, Cout, Z, N, V);
      end
    end
    in_valid = 1'b0;
    take_result();
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: got ov=%b ir=%b, expected ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(4'b0001, 8'h12, 8'h34, 1'b1, lat);
    n_tests++;
    if ({Data, Cout, Z, N, V} !== {8'h47, 4'b0000} || lat != 1) begin
      n_fail++;
      $display("FAIL b2b_first: got d=%h f=%b%b%b%b lat=%0d, expected d=47 f=0000 lat=1",
               Data, Cout, Z, N, V, lat);
    end
    take_result();
    do_op(4'b0010, 8'h10, 8'h20, 1'b1, lat);
    n_tests++;
    if ({Data, Cout, Z, N, V} !== {8'hF0, 4'b0010} || lat != 1) begin
      n_fail++;
      $display("FAIL b2b_second: got d=%h f=%b%b%b%b lat=%0d, expected d=f0 f=0010 lat=1",
               Data, Cout, Z, N, V, lat);
    end
    take_result();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; S = '0;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_mul();
    test_backpressure();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
